ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes compu_op and the forwarded operands for M-extension instructions.
- Holds the pipeline through stall_req while it iterates.
- Returns a registered result with a one-cycle done pulse; done drives the EX-finish path.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH; overflow constant is 1<<(WIDTH-1).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  valid M-extension op present in ID/EX; held high while pipeline is stalled
flush  input  1  synchronous abort of in-flight op
compu_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
src1  input  WIDTH  rs1 operand (forwarded)
src2  input  WIDTH  rs2 operand (forwarded)
stall_req  output  1  hold IF/ID/EX registers
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  registered result, held until next done

Behaviour:
Reset:
- rst=1 forces state IDLE, count 0, done 0, result 0, busy 0, all internal accumulators 0, immediately.
- A reset mid-operation discards the op; no done is produced.

FSM states: IDLE, CALC, DONE.
- IDLE, start=1, flush=0 at edge E0:
  - Latch op.
  - Latch |src1| and |src2| (absolute value for signed operands per op).
  - Latch result-sign flags.
  - Go to CALC with count=0.
- IDLE, start=1, special divide case at E0: go directly to DONE with result loaded. Special cases:
  - divisor 0: DIV/DIVU -> all ones; REM/REMU -> src1.
  - signed overflow (src1=0x80000000, src2=-1, DIV/REM only): DIV -> 0x80000000; REM -> 0.
- CALC: one step per edge; count increments.
  - Multiply: shift-add into 2*WIDTH product.
  - Divide: restoring division, one quotient bit per edge.
  - After step WIDTH-1 (edge E32 for WIDTH=32), apply sign correction, load result, go to DONE.
  - Signed multiply negates the product if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Result selection:
  - MUL -> product[WIDTH-1:0].
  - MULH/MULHSU/MULHU -> product[2*WIDTH-1:WIDTH].
- DONE: done=1 for exactly this cycle, then IDLE on the next edge unconditionally.
  - In DONE, start still high for the completing instruction must NOT relaunch; the pipeline advances on the DONE->IDLE edge.

Latency and stall:
- Normal op: done visible in the cycle after E32, i.e. 33 cycles after start is first seen.
- Special case: done in the cycle after E0.
- stall_req = (state==IDLE && start) || state==CALC. It is combinational, deasserted in DONE.

flush:
- In CALC or DONE, flush=1 returns to IDLE at the next edge; done is forced 0 and result is unchanged.
- In IDLE, flush=1 suppresses launch.
- flush has priority over start.

Arithmetic and operands:
- All arithmetic is modulo 2^WIDTH.
- src1/src2 changes after E0 are ignored.

Optional Feature:
EX_MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU compute with a single-cycle full-width signed/unsigned multiply. The unit goes IDLE->DONE at E0 (1-cycle latency, same as the divide special cases). Divide remains iterative.
- Undefined: all multiplies use the 32-step iterative path as above. Results are bit-identical in both builds.

Test Plan:
1. MUL src1=7, src2=0xFFFFFFFD -> result 0xFFFFFFEB. stall_req high for 33 cycles, then done pulses once. With EX_MULDIV_FAST_MUL_EN defined, done is in the cycle after E0.
2. Multiply-high cases:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Divide/remainder cases:
   - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
   - Each completes 33 cycles after start.
4. Special cases:
   - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
   - Each has done in the cycle after E0.
5. Flush and back-to-back:
   - Assert flush at count=10 of a DIVU -> IDLE next edge, no done, result keeps the previous value.
   - Immediately issue MUL 3x4 -> 12.
   - Back-to-back with start held high through DONE -> exactly one done per instruction.
6. Assert rst asynchronously mid-CALC (between edges) -> busy, done, result, stall_req go to 0 without a clock edge. After release, DIVU 9/3 -> 3.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// Handshake and operand bundle between the ID/EX pipeline and the RV32M mul/div unit.
interface ex_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic             flush;
  logic [2:0]       compu_op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, flush, compu_op, src1, src2,
                  input  stall_req, busy, done, result);
  modport slave  (input  start, flush, compu_op, src1, src2,
                  output stall_req, busy, done, result);
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage (shift-add multiply, restoring divide).
// Optional macro EX_MULDIV_FAST_MUL_EN: single-cycle multiplies; divides stay iterative.
//
// state  | meaning
// IDLE   | waiting for start; launches op or resolves divide special cases / fast multiply
// CALC   | one multiply or divide step per edge, WIDTH steps total
// DONE   | done pulse, result valid; returns to IDLE on next edge
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  ex_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic               is_div, s1_signed, s2_signed, sign1, sign2;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_top, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;
`ifdef EX_MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_x, fast_y, fast_p;
`endif

  always_comb begin
    is_div    = bus.compu_op[2];
    s1_signed = (bus.compu_op == OP_MULH) || (bus.compu_op == OP_MULHSU) ||
                (bus.compu_op == OP_DIV)  || (bus.compu_op == OP_REM);
    s2_signed = (bus.compu_op == OP_MULH) || (bus.compu_op == OP_DIV) ||
                (bus.compu_op == OP_REM);
    sign1     = s1_signed & bus.src1[WIDTH-1];
    sign2     = s2_signed & bus.src2[WIDTH-1];
    a_abs     = sign1 ? -bus.src1 : bus.src1;
    b_abs     = sign2 ? -bus.src2 : bus.src2;
`ifdef EX_MULDIV_FAST_MUL_EN
    fast_x    = {{WIDTH{sign1}}, bus.src1};
    fast_y    = {{WIDTH{sign2}}, bus.src2};
    fast_p    = fast_x * fast_y;
`endif

    // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_top   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_top - {1'b0, b_q};
    div_ge    = ~div_diff[WIDTH];
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
    step      = op_q[2] ? div_next : mul_next;

    prod_fix  = neg_q  ? -step : step;
    quo_fix   = neg_q  ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem_fix   = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    if (!op_q[2])
      final_res = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    else
      final_res = op_q[1] ? rem_fix : quo_fix;

    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d    = bus.compu_op;
          b_d     = b_abs;
          acc_d   = {{WIDTH{1'b0}}, a_abs};
          neg_d   = sign1 ^ sign2;
          rneg_d  = sign1;
          count_d = '0;
          if (is_div && bus.src2 == '0) begin
            result_d = bus.compu_op[1] ? bus.src1 : '1;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (is_div && !bus.compu_op[0] && bus.src1 == MIN_NEG && bus.src2 == '1) begin
            result_d = bus.compu_op[1] ? '0 : MIN_NEG;
            done_d   = 1'b1;
            state_d  = S_DONE;
`ifdef EX_MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            result_d = (bus.compu_op == OP_MUL) ? fast_p[WIDTH-1:0] : fast_p[2*WIDTH-1:WIDTH];
            done_d   = 1'b1;
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = step;
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH-1)) begin
            result_d = final_res;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Reset gates the stall so the pipeline is released even while start is still held.
  assign bus.stall_req = !rst && ((state_q == S_IDLE && bus.start) || state_q == S_CALC);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (honours EX_MULDIV_FAST_MUL_EN for multiply latency).
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] last_exp = '0;

`ifdef EX_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();
  ex_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string name);
    int lat = 0;
    int stall = 0;
    bit got = 0;
    bus.start = 1'b1; bus.compu_op = op; bus.src1 = a; bus.src2 = b;
    #1;
    while (!got && lat < 100) begin
      if (bus.stall_req === 1'b1) stall++;
      @(posedge clk); #1;
      lat++;
      if (bus.done === 1'b1) got = 1;
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL %s timeout: no done after %0d cycles", name, lat);
    end else begin
      n_tests += 3;
      if (bus.result !== exp) begin
        n_fail++; $display("FAIL %s result: got %h expected %h", name, bus.result, exp);
      end
      if (lat != exp_lat) begin
        n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      if (stall != exp_lat) begin
        n_fail++; $display("FAIL %s stall cycles: got %0d expected %0d", name, stall, exp_lat);
      end
      last_exp = exp;
      // start stays high through DONE: the next edge must return to IDLE without relaunching
      @(posedge clk); #1;
      n_tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL %s single done: done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0 || bus.stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h stall=%b expected 0 0 0 0",
               bus.busy, bus.done, bus.result, bus.stall_req);
    end
  endtask

  task automatic test_mul();
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7x-3");
  endtask

  task automatic test_mulh();
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_min_sq");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max_sq");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1_max");
  endtask

  task automatic test_div();
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "div_-7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, "rem_-7_2");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, "divu_100_7");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT, "remu_100_7");
  endtask

  task automatic test_special();
    do_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT, "div_by_zero");
    do_op(3'd7, 32'd5, 32'd0, 32'd5, SPC_LAT, "remu_by_zero");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT, "div_overflow");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPC_LAT, "rem_overflow");
  endtask

  task automatic test_flush();
    bit saw_done = 0;
    bus.start = 1'b1; bus.compu_op = 3'd5; bus.src1 = 32'd1000; bus.src2 = 32'd3;
    #1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1;
    end
    bus.start = 1'b0; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_tests += 3;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL flush busy: got %b expected 0", bus.busy);
    end
    if (bus.result !== last_exp) begin
      n_fail++; $display("FAIL flush result: got %h expected %h", bus.result, last_exp);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) saw_done = 1;
    end
    if (saw_done) begin
      n_fail++; $display("FAIL flush done: got 1 expected 0");
    end
    do_op(3'd0, 32'd3, 32'd4, 32'd12, MUL_LAT, "mul_after_flush");
  endtask

  task automatic test_back_to_back();
    do_op(3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT, "b2b_divu");
    do_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT, "b2b_div0");
    do_op(3'd0, 32'd3, 32'd4, 32'd12, MUL_LAT, "b2b_mul");
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    bus.start = 1'b1; bus.compu_op = 3'd5; bus.src1 = 32'd50; bus.src2 = 32'd5;
    #1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    n_tests += 4;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL async_rst busy: got %b expected 0", bus.busy);
    end
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL async_rst done: got %b expected 0", bus.done);
    end
    if (bus.result !== 32'h0) begin
      n_fail++; $display("FAIL async_rst result: got %h expected 0", bus.result);
    end
    if (bus.stall_req !== 1'b0) begin
      n_fail++; $display("FAIL async_rst stall_req: got %b expected 0", bus.stall_req);
    end
    #2 rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    do_op(3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT, "divu_9_3_after_rst");
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.compu_op = 3'd0; bus.src1 = '0; bus.src2 = '0;
    #12;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
